// File: rtl/synth_pkg.sv
// Package shared by the voice arbiter and its consumers.
//  - HP_W       : half-period width expected by freq_synth
//  - arb_state_t: arbiter state encoding (2'd3 is illegal)
//  - NOTE_*     : half-period constants for common pitches. The half-period is
//                 inversely proportional to pitch, anchored at NOTE_B1 = 100.
package synth_pkg;

   localparam int HP_W = 7;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_PLAY = 2'd1,
      ARB_GAP  = 2'd2
   } arb_state_t;

   localparam logic [HP_W-1:0] NOTE_B1 = 7'd100;
   localparam logic [HP_W-1:0] NOTE_D2 = 7'd84;
   localparam logic [HP_W-1:0] NOTE_C3 = 7'd47;
   localparam logic [HP_W-1:0] NOTE_A3 = 7'd28;

endpackage

// File: rtl/synth_voice_arbiter_prio_pick.sv
// prio_pick: combinational lowest-index-first encoder.
// Ports:
//  req    in   N    request vector
//  idx    out  IW   index of the lowest set bit (0 when none)
//  valid  out  1    any bit of req set
module prio_pick #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scan from the top down so the lowest set index is the one left standing.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IW'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/synth_voice_arbiter.sv
// synth_voice_arbiter: shares one freq_synth among NUM_REQ note sources.
// Fixed priority (index 0 highest), a minimum hold before a higher source may
// preempt, and a silent gap between consecutive notes.
// Ports:
//  clk     in   1             system clock
//  rst_n   in   1             synchronous active-low reset
//  tick    in   1             1-clk tempo strobe
//  req     in   NUM_REQ       per-source note request (level)
//  req_hp  in   NUM_REQ*HP_W  per-source half-period, slice i = [i*HP_W +: HP_W]
//  grant   out  NUM_REQ       one-hot owner, registered
//  hp      out  HP_W          half-period to freq_synth, registered
//  active  out  1             tone enable to freq_synth, registered
//  busy    out  1             state is PLAY or GAP
module synth_voice_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int HP_W      = synth_pkg::HP_W,
   parameter int HOLD_W    = 4,
   parameter int MIN_HOLD  = 4,
   parameter int GAP_TICKS = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    tick,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*HP_W-1:0] req_hp,
   output logic [NUM_REQ-1:0]      grant,
   output logic [HP_W-1:0]         hp,
   output logic                    active,
   output logic                    busy
);
   import synth_pkg::*;

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
   localparam logic [HOLD_W-1:0] GAP_MAX  = HOLD_W'(GAP_TICKS);

   arb_state_t         state;
   logic [IDX_W-1:0]   owner;
   logic [HOLD_W-1:0]  hold_ctr;
   logic [HOLD_W-1:0]  gap_ctr;

   logic [IDX_W-1:0]   pick_idx;
   logic               pick_vld;
   logic [IDX_W-1:0]   hi_idx;
   logic               hi_vld;
   logic [NUM_REQ-1:0] hi_req;
   logic [HP_W-1:0]    pick_hp;
   logic [HP_W-1:0]    own_hp;
   logic               rel;
   logic               preempt;

   // New owner selection out of IDLE.
   prio_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
      .req   (req),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   // grant is one-hot while playing, so grant-1 masks exactly the indices
   // above the owner in priority (lower index numbers).
   assign hi_req = req & (grant - NUM_REQ'(1));

   prio_pick #(.N(NUM_REQ), .IW(IDX_W)) u_hi (
      .req   (hi_req),
      .idx   (hi_idx),
      .valid (hi_vld)
   );

   // Half-period muxes: one for the candidate owner, one for the current owner.
   always_comb begin
      pick_hp = '0;
      own_hp  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDX_W'(i)) pick_hp = req_hp[i*HP_W +: HP_W];
         if (owner    == IDX_W'(i)) own_hp  = req_hp[i*HP_W +: HP_W];
      end
   end

   assign rel     = !req[owner];
   // hi_idx < owner is implied by the mask; kept as an explicit guard.
   assign preempt = hi_vld && (hi_idx < owner) && (hold_ctr == HOLD_MAX);

   assign busy = (state == ARB_PLAY) || (state == ARB_GAP);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ARB_IDLE;
         owner    <= '0;
         grant    <= '0;
         hp       <= '0;
         active   <= 1'b0;
         hold_ctr <= '0;
         gap_ctr  <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_vld) begin
                  state    <= ARB_PLAY;
                  owner    <= pick_idx;
                  grant    <= NUM_REQ'(1) << pick_idx;
                  hp       <= pick_hp;
                  active   <= (pick_hp != '0);
                  hold_ctr <= '0;
               end
            end
            ARB_PLAY: begin
               // Leaving PLAY wins over a coincident tick: hp and the hold
               // count are not updated on the way out.
               if (rel || preempt) begin
                  state    <= ARB_GAP;
                  grant    <= '0;
                  active   <= 1'b0;
                  hold_ctr <= '0;
                  gap_ctr  <= '0;
               end else if (tick) begin
                  hp     <= own_hp;
                  active <= (own_hp != '0);
                  if (hold_ctr != HOLD_MAX) hold_ctr <= hold_ctr + HOLD_W'(1);
               end
            end
            ARB_GAP: begin
               if (gap_ctr == GAP_MAX) begin
                  state   <= ARB_IDLE;
                  gap_ctr <= '0;
               end else if (tick) begin
                  gap_ctr <= gap_ctr + HOLD_W'(1);
               end
            end
            default: begin
               state    <= ARB_IDLE;
               owner    <= '0;
               grant    <= '0;
               hp       <= '0;
               active   <= 1'b0;
               hold_ctr <= '0;
               gap_ctr  <= '0;
            end
         endcase
      end
   end

endmodule
